// File: rtl/alu_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_pkg
// Description : Shared types and constants for the ALU sharing controller.
//               Holds the controller state encoding, the bit positions of
//               the captured {c,z,o,s} flags and the opsel width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Bit positions inside the 4-bit response flag vector {c,z,o,s}
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_O = 1;
    localparam int FLAG_S = 0;

    localparam int OPSEL_W = 3;

endpackage
`default_nettype wire

// File: rtl/alu_share_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first set
//               request at or after the pointer, wrapping modulo NREQ.
// Ports       : i_req       - request vector
//               i_ptr       - highest-priority index (must be < NREQ)
//               o_grant     - one-hot grant (zero when nothing requests)
//               o_grant_idx - index of the granted requester
//               o_any_grant - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_idx,
    output logic            o_any_grant
);

    logic [2*NREQ-1:0] w_dbl;
    logic [IDW:0]      w_sum;

    always_comb begin
        // Rotating a doubled copy puts the pointer's requester at bit 0, so
        // the lowest set bit k is the winner at offset k from the pointer.
        w_dbl       = {i_req, i_req} >> i_ptr;
        w_sum       = '0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        // Scan from the farthest offset down so the nearest one is kept.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
                if (w_sum >= (IDW+1)'(NREQ)) begin
                    w_sum = w_sum - (IDW+1)'(NREQ);
                end
                o_grant_idx = w_sum[IDW-1:0];
                o_any_grant = 1'b1;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (o_any_grant && (o_grant_idx == IDW'(j))) begin
                o_grant[j] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl
// Description : Shares one combinational ALU between NREQ requesters.
//               Round-robin picks a requester, its operands are registered
//               onto the ALU inputs, the result and flags are captured one
//               cycle later and returned on a valid/ready response channel.
// Ports       : clk, rst                      - clock, sync active-high reset
//               req_valid/req_ready           - request handshake per requester
//               req_op1/op2/opsel/mode        - flattened request operands
//               alu_op1/op2/opsel/mode        - registered ALU inputs
//               alu_result, alu_*_flag        - ALU outputs
//               rsp_valid/rsp_ready           - response handshake per requester
//               rsp_result/rsp_flags/rsp_id   - captured response and owner
//               busy                          - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int DWIDTH = 128,
    parameter int NREQ   = 2,
    parameter int IDW    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DWIDTH-1:0]    req_op1,
    input  logic [NREQ*DWIDTH-1:0]    req_op2,
    input  logic [NREQ*OPSEL_W-1:0]   req_opsel,
    input  logic [NREQ-1:0]           req_mode,
    output logic [DWIDTH-1:0]         alu_op1,
    output logic [DWIDTH-1:0]         alu_op2,
    output logic [OPSEL_W-1:0]        alu_opsel,
    output logic                      alu_mode,
    input  logic [DWIDTH-1:0]         alu_result,
    input  logic                      alu_c_flag,
    input  logic                      alu_z_flag,
    input  logic                      alu_o_flag,
    input  logic                      alu_s_flag,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [DWIDTH-1:0]         rsp_result,
    output logic [3:0]                rsp_flags,
    output logic [IDW-1:0]            rsp_id,
    output logic                      busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDW-1:0]      r_rr_ptr;
    logic [IDW-1:0]      r_id;
    logic [DWIDTH-1:0]   r_alu_op1;
    logic [DWIDTH-1:0]   r_alu_op2;
    logic [OPSEL_W-1:0]  r_alu_opsel;
    logic                r_alu_mode;
    logic [DWIDTH-1:0]   r_rsp_result;
    logic [3:0]          r_rsp_flags;

    logic [NREQ-1:0]     w_grant;
    logic [IDW-1:0]      w_grant_idx;
    logic                w_any_grant;
    logic                w_take;
    logic                w_rsp_hs;
    logic [IDW-1:0]      w_ptr_nxt;
    logic [DWIDTH-1:0]   w_sel_op1;
    logic [DWIDTH-1:0]   w_sel_op2;
    logic [OPSEL_W-1:0]  w_sel_opsel;
    logic                w_sel_mode;
    logic [3:0]          w_flags;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    // A grant is withheld while rst is high: the state is being forced to
    // IDLE, so an accepted request would be lost without a response.
    assign w_take = (r_state == IDLE) && !rst && w_any_grant;

    assign w_ptr_nxt = (w_grant_idx == IDW'(NREQ - 1)) ? '0 : (w_grant_idx + 1'b1);

    // Operand mux driven by the one-hot grant
    always_comb begin
        w_sel_op1   = '0;
        w_sel_op2   = '0;
        w_sel_opsel = '0;
        w_sel_mode  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_op1   = req_op1[i*DWIDTH +: DWIDTH];
                w_sel_op2   = req_op2[i*DWIDTH +: DWIDTH];
                w_sel_opsel = req_opsel[i*OPSEL_W +: OPSEL_W];
                w_sel_mode  = req_mode[i];
            end
        end
    end

    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_C] = alu_c_flag;
        w_flags[FLAG_Z] = alu_z_flag;
        w_flags[FLAG_O] = alu_o_flag;
        w_flags[FLAG_S] = alu_s_flag;
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_rsp_hs    = 1'b0;
        rsp_valid   = '0;
        req_ready   = w_take ? w_grant : '0;
        busy        = (r_state != IDLE);
        // Only the owner's rsp_ready completes the response.
        for (int i = 0; i < NREQ; i++) begin
            if ((r_state == RESP) && (r_id == IDW'(i))) begin
                rsp_valid[i] = 1'b1;
                w_rsp_hs     = rsp_ready[i];
            end
        end
        case (r_state)
            IDLE:    if (w_any_grant) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_alu_opsel  <= '0;
            r_alu_mode   <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            if (w_take) begin
                r_alu_op1   <= w_sel_op1;
                r_alu_op2   <= w_sel_op2;
                r_alu_opsel <= w_sel_opsel;
                r_alu_mode  <= w_sel_mode;
                r_id        <= w_grant_idx;
                r_rr_ptr    <= w_ptr_nxt;
            end
            // The ALU has had the whole EXEC cycle to settle.
            if (r_state == EXEC) begin
                r_rsp_result <= alu_result;
                r_rsp_flags  <= w_flags;
            end
        end
    end

    assign alu_op1    = r_alu_op1;
    assign alu_op2    = r_alu_op2;
    assign alu_opsel  = r_alu_opsel;
    assign alu_mode   = r_alu_mode;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_id     = r_id;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_ctrl
// Description : Self-checking bench for alu_share_ctrl with three requesters,
//               a stub ALU and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

    localparam int N  = 3;
    localparam int DW = 128;
    localparam int IW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rst_d = 1'b1;
    logic [N-1:0]     req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
    logic [N*DW-1:0]  req_op1, req_op2;
    logic [N*3-1:0]   req_opsel;
    logic [DW-1:0]    alu_op1, alu_op2, alu_result, rsp_result;
    logic [2:0]       alu_opsel;
    logic             alu_mode, alu_c_flag, alu_z_flag, alu_o_flag, alu_s_flag;
    logic [3:0]       rsp_flags;
    logic [IW-1:0]    rsp_id;
    logic             busy;

    // Requester-side stimulus state
    logic [N-1:0]     v = '0;
    logic [N-1:0]     persist = '0;
    logic [DW-1:0]    op1_a [N];
    logic [DW-1:0]    op2_a [N];
    logic [2:0]       sel_a [N];
    logic [N-1:0]     mode_v = '0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rst_d <= rst;

    always_comb begin
        req_valid = v;
        req_mode  = mode_v;
        req_op1   = '0;
        req_op2   = '0;
        req_opsel = '0;
        for (int i = 0; i < N; i++) begin
            req_op1[i*DW +: DW] = op1_a[i];
            req_op2[i*DW +: DW] = op2_a[i];
            req_opsel[i*3 +: 3] = sel_a[i];
        end
    end

    // Reference ALU: add/sub, logic ops, pass-through and a saturated case.
    function automatic logic [DW+3:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [2:0] sel, input logic m);
        logic [DW:0]   s;
        logic [DW-1:0] r;
        logic          c, o;
        c = 1'b0; o = 1'b0; s = '0;
        case (sel)
            3'd0: begin
                s = m ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
                r = s[DW-1:0];
                c = s[DW];
                o = m ? ((a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]))
                      : ((a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]));
            end
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: r = a ^ b;
            3'd7: return {{DW{1'b1}}, 4'b0100};
            default: r = a;
        endcase
        return {r, c, (r == '0), o, r[DW-1]};
    endfunction

    logic [DW+3:0] stub;
    always_comb begin
        stub = alu_ref(alu_op1, alu_op2, alu_opsel, alu_mode);
        alu_result = stub[DW+3:4];
        alu_c_flag = stub[3];
        alu_z_flag = stub[2];
        alu_o_flag = stub[1];
        alu_s_flag = stub[0];
    end

    alu_share_ctrl #(.DWIDTH(DW), .NREQ(N), .IDW(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_opsel(req_opsel), .req_mode(req_mode),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opsel(alu_opsel), .alu_mode(alu_mode),
        .alu_result(alu_result), .alu_c_flag(alu_c_flag), .alu_z_flag(alu_z_flag),
        .alu_o_flag(alu_o_flag), .alu_s_flag(alu_s_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_id(rsp_id), .busy(busy)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // First valid requester at or after p, wrapping; -1 when none.
    function automatic int rr_pick(input logic [N-1:0] vv, input int p);
        for (int k = 0; k < N; k++) begin
            if (vv[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // ---------------- transaction-level model / monitor ----------------
    logic          mon_en = 1'b0;
    logic [N-1:0]  acc_vec = '0;     // requests accepted at the coming edge
    int            m_ptr = 0, m_own = 0, m_age = 0;
    logic          m_busy = 1'b0;
    logic [DW-1:0] e_op1 = '0, e_op2 = '0;
    logic [2:0]    e_sel = '0;
    logic          e_mode = 1'b0;
    logic [DW+3:0] m_exp = '0;
    int            grant_q [$];
    logic [DW-1:0] res_q [$];

    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy, exp_rv;
        acc_vec = '0;
        if (mon_en) begin
            if (rst_d) begin
                m_busy = 1'b0; m_ptr = 0; m_age = 0;
                e_op1 = '0; e_op2 = '0; e_sel = '0; e_mode = 1'b0;
                check_val("rst_rsp_result", rsp_result, '0);
                check_val("rst_rsp_flags", rsp_flags, '0);
                check_val("rst_rsp_id", rsp_id, '0);
            end
            exp_rdy = '0;
            g = -1;
            if (!m_busy && !rst) begin
                g = rr_pick(req_valid, m_ptr);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            check_val("req_ready", req_ready, exp_rdy);
            check_val("busy", busy, m_busy);
            check_val("alu_op1", alu_op1, e_op1);
            check_val("alu_op2", alu_op2, e_op2);
            check_val("alu_opsel", alu_opsel, e_sel);
            check_val("alu_mode", alu_mode, e_mode);
            exp_rv = (m_busy && m_age >= 2) ? (N'(1) << m_own) : '0;
            check_val("rsp_valid", rsp_valid, exp_rv);
            if (m_busy && m_age >= 2) begin
                check_val("rsp_id", rsp_id, m_own);
                check_val("rsp_result", rsp_result, m_exp[DW+3:4]);
                check_val("rsp_flags", rsp_flags, m_exp[3:0]);
            end
            if (!rst) begin
                if (g >= 0) begin
                    acc_vec[g] = 1'b1;
                    m_own = g; m_busy = 1'b1; m_age = 1;
                    m_ptr = (g + 1) % N;
                    e_op1 = op1_a[g]; e_op2 = op2_a[g]; e_sel = sel_a[g]; e_mode = mode_v[g];
                    m_exp = alu_ref(op1_a[g], op2_a[g], sel_a[g], mode_v[g]);
                    grant_q.push_back(g);
                end else if (m_busy) begin
                    if (m_age == 1) m_age = 2;
                    else if (rsp_ready[m_own]) begin
                        m_busy = 1'b0;
                        res_q.push_back(m_exp[DW+3:4]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) if (acc_vec[i] && !persist[i]) v[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    endtask

    task automatic load(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [2:0] s, input logic m);
        op1_a[i] = a; op2_a[i] = b; sel_a[i] = s; mode_v[i] = m; v[i] = 1'b1;
    endtask

    task automatic wait_acc(input int idx, input int budget);
        logic got;
        got = 1'b0;
        for (int n = 0; n < budget; n++) begin
            cyc();
            if (acc_vec[idx]) begin got = 1'b1; break; end
        end
        check_val("accept_seen", got, 1'b1);
    endtask

    task automatic run_quiet(input int budget);
        int n;
        n = 0;
        while (((v != '0) || busy) && n < budget) begin cyc(); n++; end
        check_val("drain_done", ((v != '0) || busy), 1'b0);
    endtask

    function automatic logic [DW-1:0] rnd();
        case ($urandom_range(0, 3))
            0: return '1;
            1: return DW'($urandom_range(0, 15));
            default: return {$urandom, $urandom, $urandom, $urandom};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin op1_a[i] = '0; op2_a[i] = '0; sel_a[i] = '0; end
        rsp_ready = '0;
        @(posedge clk); #1 mon_en = 1'b1;
        cyc(); rst = 1'b0;

        // Reset in the middle of EXEC drops the op silently
        rsp_ready = '1;
        load(0, 128'd9, 128'd4, 3'd0, 1'b0);
        wait_acc(0, 10);
        rst = 1'b1; cyc(); cyc();
        check_val("mid_rst_busy", busy, 1'b0);
        check_val("mid_rst_valid", rsp_valid, '0);
        check_val("mid_rst_op1", alu_op1, '0);
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin cyc(); check_val("no_rsp_after_rst", rsp_valid, '0); end

        // Single request: 5 + 3
        do_reset();
        load(0, 128'd5, 128'd3, 3'd0, 1'b0);
        wait_acc(0, 10);
        check_val("single_op1", alu_op1, 128'd5);
        check_val("single_exec_valid", rsp_valid, '0);
        cyc();
        check_val("single_valid", rsp_valid, 3'b001);
        check_val("single_result", rsp_result, 128'd8);
        check_val("single_id", rsp_id, 0);
        check_val("single_flags", rsp_flags, 4'b0000);
        cyc();
        check_val("single_idle", busy, 1'b0);

        // Simultaneous persistent requesters alternate
        load(0, 128'd1, 128'd0, 3'd6, 1'b0);
        load(1, 128'd2, 128'd0, 3'd6, 1'b0);
        persist = 3'b011;
        do_reset();
        grant_q.delete(); res_q.delete();
        for (int n = 0; n < 18; n++) cyc();
        persist = '0;
        run_quiet(40);
        check_val("alt_count", (grant_q.size() >= 4 && res_q.size() >= 4), 1'b1);
        if (grant_q.size() >= 4 && res_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check_val("alt_grant", grant_q[k], k % 2);
                check_val("alt_result", res_q[k], (k % 2) + 1);
            end
        end

        // Backpressure, then wrong-index ready
        do_reset();
        rsp_ready = '0;
        load(1, rnd(), rnd(), 3'd7, 1'b1);
        wait_acc(1, 10);
        load(0, 128'd7, 128'd7, 3'd1, 1'b0);
        cyc();
        for (int n = 0; n < 5; n++) begin
            check_val("bp_valid", rsp_valid, 3'b010);
            check_val("bp_result", rsp_result, {DW{1'b1}});
            check_val("bp_flags", rsp_flags, 4'b0100);
            check_val("bp_no_ready", req_ready, '0);
            cyc();
        end
        rsp_ready = 3'b101;
        for (int n = 0; n < 2; n++) begin
            cyc();
            check_val("wrong_idx_busy", busy, 1'b1);
            check_val("wrong_idx_valid", rsp_valid, 3'b010);
        end
        rsp_ready = 3'b010;
        cyc();
        check_val("bp_release_idle", busy, 1'b0);
        check_val("bp_next_grant", req_ready, 3'b001);
        rsp_ready = '1;
        run_quiet(30);

        // Wrap-around with three requesters
        do_reset();
        grant_q.delete();
        load(1, 128'd11, 128'd1, 3'd0, 1'b0);
        run_quiet(20);
        load(0, 128'd20, 128'd2, 3'd2, 1'b0);
        load(2, 128'd30, 128'd3, 3'd3, 1'b0);
        run_quiet(30);
        for (int i = 0; i < N; i++) load(i, rnd(), rnd(), 3'd0, 1'b1);
        run_quiet(40);
        check_val("wrap_count", grant_q.size(), 6);
        if (grant_q.size() == 6) begin
            check_val("wrap_g0", grant_q[0], 1);
            check_val("wrap_g1", grant_q[1], 2);
            check_val("wrap_g2", grant_q[2], 0);
            check_val("wrap_g3", grant_q[3], 1);
        end

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            cyc();
            if ($urandom_range(0, 400) == 0) begin
                rst = 1'b1; cyc(); cyc(); rst = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 2) == 0)
                    load(i, rnd(), rnd(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            rsp_ready = N'($urandom);
        end
        rsp_ready = '1;
        run_quiet(60);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares one combinational 128-bit ALU (op1/op2/opsel/mode in; result plus c/z/o/s flags out) between NREQ requesters.
- Round-robin arbitration over valid/ready request channels.
- Registers the granted operands onto the ALU inputs and captures result and flags one cycle later.
- Returns them to the winning requester on a valid/ready response channel. Sits between the requester datapaths and the ALU instance.

Parameters:
- DWIDTH, 128, operand/result width; must match the ALU instance.
- NREQ, 2, number of requesters (2..8).
- IDW, 3, width of requester index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_op1  in  NREQ*DWIDTH  flattened op1; slice i = [i*DWIDTH +: DWIDTH]
- req_op2  in  NREQ*DWIDTH  flattened op2, same slicing
- req_opsel  in  NREQ*3  flattened opsel; opaque to this block
- req_mode  in  NREQ  per-requester mode bit
- alu_op1  out  DWIDTH  registered operand to ALU
- alu_op2  out  DWIDTH  registered operand to ALU
- alu_opsel  out  3  registered opsel to ALU
- alu_mode  out  1  registered mode to ALU
- alu_result  in  DWIDTH  ALU result (combinational from alu_* outputs)
- alu_c_flag, alu_z_flag, alu_o_flag, alu_s_flag  in  1 each  ALU flags
- rsp_valid  out  NREQ  per-requester response valid; one-hot or zero
- rsp_ready  in  NREQ  per-requester response accept
- rsp_result  out  DWIDTH  captured result (shared by all requesters)
- rsp_flags  out  4  captured {c,z,o,s}
- rsp_id  out  IDW  index of requester owning the current response
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset and IDLE:
  - Synchronous reset: state=IDLE, rr pointer=0 (requester 0 highest priority).
  - All outputs reset to 0: alu_*, rsp_*, req_ready, busy.
  - Reset mid-operation drops the in-flight op silently; no response is issued.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: if any req_valid is set, the arbiter picks the first valid requester at or after the rr pointer, wrapping modulo NREQ.
  - req_ready[g] is asserted combinationally in that cycle only (state==IDLE && grant g).
  - On that edge: alu_op1/op2/opsel/mode <= slice g; id <= g; rr pointer <= (g+1) mod NREQ; state <= EXEC.
  - No request pending: stay in IDLE; alu_* hold their previous values.
  - EXEC (1 cycle): ALU settles. At the edge: rsp_result <= alu_result; rsp_flags <= {c,z,o,s}; state <= RESP.
  - RESP: rsp_valid[id]=1 and rsp_id=id. rsp_result, rsp_flags and rsp_id are held stable until rsp_ready[id].
  - rsp_ready on other indices is ignored.
  - On the handshake edge: state <= IDLE.
- Handshake rules:
  - req_ready is always 0 outside IDLE, so requester valid/data must be held.
  - No grant is made in the same cycle as a response handshake.
  - A request accepted at edge T gets rsp_valid high after edge T+2.
  - Minimum period is 3 cycles per op.
- Persistent requester: the rr pointer advance guarantees every other valid requester is served before the same requester wins again.
- rsp_valid is registered (driven from state), not a combinational function of inputs.

Decomposition:
- Package alu_share_pkg:
  - state enum (IDLE, EXEC, RESP), 2-bit;
  - flag index constants FLAG_C=3, FLAG_Z=2, FLAG_O=1, FLAG_S=0;
  - OPSEL_W=3.
- Sub-module rr_arbiter (params NREQ, IDW):
  - inputs: req vector, pointer;
  - outputs: one-hot grant, grant index, any_grant.
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Reset check: assert rst 2 cycles mid-EXEC with r0 requesting -> all outputs 0 the next cycle, no rsp_valid afterwards, busy=0.
- Single request: r0 sends op1=5, op2=3, opsel=3'b000, mode=0; stub ALU returns 8 with flags 0000.
  - Required: req_ready[0] high for exactly 1 cycle; alu_op1=5 from T+1; rsp_valid[0] high after T+2.
  - Required: rsp_result=8, rsp_id=0, rsp_flags=4'b0000.
- Simultaneous requests: r0 and r1 both valid continuously from reset -> grants in order 0,1,0,1; each response carries the matching op1 (r0 op1=1, r1 op1=2).
- Response backpressure: hold rsp_ready=0 for 5 cycles with ALU result 128'hFFFF_..._FFFF and z=1.
  - Required: rsp_valid, rsp_result and rsp_flags=4'b0100 stable all 5 cycles; no req_ready during the stall.
  - Required: return to IDLE one cycle after rsp_ready=1.
- Wrong-index ready: rsp_id=1 with rsp_ready=2'b01 -> no handshake, state stays RESP.
- Wrap-around, NREQ=3: rr pointer=2 with r0 and r2 valid -> r2 granted first, then r0, pointer ends at 1.
